a0_uart_logger: RTL and testbench
=================================

# a0_uart_logger

Downstream consumer of the processor's `a0` result register. It captures every change of `a0` into a small FIFO and serialises each captured word over a transmit-only UART (8N1). Bench and board can then read the program's result stream without probing the pipeline. It instantiates next to the CPU top level and is fed directly from its `a0` output.

## Interface
Parameters:
- `WIDTH`, default 32: width of `a0`. Must be a multiple of 8.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be ≥ 2.
- `FIFO_DEPTH`, default 8: number of captured words buffered. Must be a power of 2, ≥ 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `a0`, in, WIDTH: live `a0` value from the register file.
- `tx`, out, 1: UART serial line; idle high.
- `busy`, out, 1: high while a word is being transmitted (any state but IDLE).
- `overflow`, out, 1: sticky; set when a change is dropped because the FIFO is full.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: number of words currently queued.

## Operation
- **Change detect:** register `last_a0` resets to 0. On an edge where `a0 != last_a0`:
  - `last_a0 <= a0`;
  - the new value is pushed into the FIFO.
- **Overflow:** if a push is requested while the FIFO is full and no pop happens that edge, the word is dropped and `overflow <= 1`.
  - `last_a0` still updates, so the same value is not retried.
- **Simultaneous push and pop:** allowed when full. Count is unchanged and nothing is dropped.
- **Transmitter FSM:** states IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the word into `shift_word`, set `byte_idx = 0`, go to START.
  - START: `tx = 0` for CLKS_PER_BIT cycles, then go to DATA with `bit_idx = 0`.
  - DATA: `tx` = bit `bit_idx` of the current byte, LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: `tx = 1` for CLKS_PER_BIT cycles. Then:
    - if `byte_idx == WIDTH/8-1`, go to IDLE;
    - otherwise increment `byte_idx` and go to START (no extra idle between bytes).
- **Byte order:** most-significant byte first, i.e. byte k is `shift_word[WIDTH-1-8k -: 8]`.
- **Counters:**
  - `baud_cnt` counts 0..CLKS_PER_BIT-1 and resets on every state change.
  - `bit_idx` is 3 bits.
  - `byte_idx` has width $clog2(WIDTH/8), minimum 1.
- **`tx` is registered:** it is driven from the state and shift data registered at the same edge. No combinational path runs from `a0` to `tx`.

## Timing
- **Reset values:**
  - `tx = 1`, `busy = 0`, `overflow = 0`, `fifo_count = 0`;
  - state IDLE, `last_a0 = 0`, FIFO empty.
- **Capture latency:** `a0` changes before edge k, so the word is queued after edge k.
  - With the transmitter idle, the pop happens at edge k+1.
  - `tx` goes low and `busy` goes high after edge k+1.
- **Frame lengths:**
  - one byte = 10·CLKS_PER_BIT cycles;
  - one word = (WIDTH/8)·10·CLKS_PER_BIT cycles;
  - back-to-back words have exactly 1 IDLE cycle between them (the last STOP exits to IDLE, and IDLE pops on the next edge).
- **Reset mid-frame:** at the next edge `tx = 1`, state IDLE, FIFO cleared, `overflow` cleared. The partial word is discarded.
- **Changes during transmission:** `a0` changing while the transmitter is busy only queues the new value. The word in flight is never altered.

## Structure
- Package `a0_logger_pkg` holds:
  - `tx_state_t` enum (IDLE, START, DATA, STOP);
  - constants `UART_START_BIT = 1'b0`, `UART_STOP_BIT = 1'b1`, `BITS_PER_BYTE = 8`.
- Sub-module `sync_fifo`:
  - parameters WIDTH and DEPTH;
  - push/pop/full/empty/count;
  - simultaneous push and pop when full is legal;
  - synchronous active-high `rst`.
- Top of block holds the change detector, the transmitter FSM and the counters.

## Test plan
All scenarios use WIDTH=32, CLKS_PER_BIT=4, FIFO_DEPTH=4.
1. **Reset:** hold `rst` 3 cycles with `a0 = 0` → `tx = 1`, `busy = 0`, `fifo_count = 0`. No transmission for 200 cycles.
2. **Single word:** set `a0 = 32'hDEADBEEF` for 1 cycle, then keep it stable.
   - `busy` rises 2 edges later.
   - `tx` decodes bytes DE, AD, BE, EF, each LSB first.
   - Total 160 cycles, then `busy = 0`.
3. **Burst:**
   - Change `a0` to 1, 2, 3, 4, 5, 6 on consecutive cycles → first word transmits; `fifo_count` peaks at 4.
   - The sixth change finds the FIFO full and is dropped; `overflow = 1`.
   - Received words: 1, 2, 3, 4, 5.
4. **Back-to-back words:** queue 32'h00000001 and 32'h00000002 → exactly 1 idle-high cycle between the last STOP of word 1 and the START of word 2.
5. **Reset mid-frame:**
   - Assert `rst` during byte 2 of 32'h12345678 → `tx = 1` the next cycle and `fifo_count = 0`.
   - After release, with `a0` still 32'h12345678, the full word is retransmitted once (because `last_a0` reset to 0).
6. **No-change filter:** hold `a0 = 32'h00000007` for 500 cycles → exactly one word is sent.

Source files
------------

// File: rtl/a0_uart_logger_pkg.sv
// Shared types and UART framing constants for the a0 result logger.
package a0_logger_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   BITS_PER_BYTE  = 8;

endpackage

// File: rtl/a0_uart_logger_sync_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may share an edge even when full.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       popData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  // push/pop act like valid with an implicit ready: a pop is taken only when not empty,
  // a push only when not full unless the same edge also pops.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/a0_uart_logger.sv
// Captures every change of the CPU a0 register into a FIFO and sends each word MSB-byte first
// over an 8N1 transmit-only UART.
module a0_uart_logger
  import a0_logger_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            a0,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int NUM_BYTES = WIDTH / BITS_PER_BYTE;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(BITS_PER_BYTE - 1);

  logic [WIDTH-1:0]  lastA0;
  logic              change;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [WIDTH-1:0]  fifoData;

  tx_state_t         state;
  tx_state_t         stateNext;
  logic [CNT_W-1:0]  baudCnt;
  logic              baudDone;
  logic [2:0]        bitIdx;
  logic [2:0]        bitIdxNext;
  logic [BYTE_W-1:0] byteIdx;
  logic [WIDTH-1:0]  shiftWord;
  logic [7:0]        curByte;
  logic              txNext;

  assign change   = (a0 != lastA0);
  assign baudDone = (baudCnt == BAUD_LAST);
  assign curByte  = 8'(shiftWord >> (WIDTH - BITS_PER_BYTE * (int'(byteIdx) + 1)));

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (change),
    .pushData (a0),
    .pop      (fifoPop),
    .popData  (fifoData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifo_count)
  );

  // lastA0 follows a0 even when the push is dropped, so a lost value is never retried.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastA0   <= '0;
      overflow <= 1'b0;
    end else begin
      if (change) lastA0 <= a0;
      if (change && fifoFull && !fifoPop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baudCnt   <= '0;
      bitIdx    <= '0;
      byteIdx   <= '0;
      shiftWord <= '0;
      tx        <= UART_STOP_BIT;
    end else begin
      state   <= stateNext;
      bitIdx  <= bitIdxNext;
      tx      <= txNext;
      baudCnt <= (state == IDLE || baudDone) ? '0 : baudCnt + 1'b1;
      if (fifoPop) begin
        shiftWord <= fifoData;
        byteIdx   <= '0;
      end else if (state == STOP && stateNext == START) begin
        byteIdx <= byteIdx + 1'b1;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    bitIdxNext = bitIdx;
    case (state)
      IDLE:  if (!fifoEmpty) stateNext = START;
      START: if (baudDone) begin
        stateNext  = DATA;
        bitIdxNext = '0;
      end
      DATA:  if (baudDone) begin
        if (bitIdx == LAST_BIT) stateNext = STOP;
        else                    bitIdxNext = bitIdx + 1'b1;
      end
      STOP:  if (baudDone) stateNext = (byteIdx == LAST_BYTE) ? IDLE : START;
      default: stateNext = IDLE;
    endcase
  end

  // tx is precomputed from the next state so the line itself comes straight off a flop.
  always_comb begin
    fifoPop = (state == IDLE) && !fifoEmpty;
    busy    = (state != IDLE);
    case (stateNext)
      START:   txNext = UART_START_BIT;
      DATA:    txNext = curByte[bitIdxNext];
      default: txNext = UART_STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_a0_uart_logger.sv
// Directed bench for a0_uart_logger: frame timing, byte order, FIFO overflow and reset behaviour.
module tb_a0_uart_logger;

  localparam int WIDTH = 32;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int WORD_CYCLES = (WIDTH / 8) * 10 * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   a0;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];

  a0_uart_logger #(
    .WIDTH        (WIDTH),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a0         (a0),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receive one byte by mid-bit sampling; ok drops on timeout or bad framing.
  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int guard = 0;
    ok = 1'b1;
    b  = '0;
    while (tx !== 1'b0) begin
      if (guard == 1000) begin
        ok = 1'b0;
        return;
      end
      guard++;
      @(negedge clk);
    end
    repeat (CPB / 2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b = {tx, b[7:1]};
    end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_words(input int n);
    logic [7:0]       b;
    bit               ok;
    logic [WIDTH-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = '0;
      for (int j = 0; j < WIDTH / 8; j++) begin
        rx_byte(b, ok);
        n_checks++;
        if (!ok) begin
          n_fail++;
          $display("FAIL rx_framing: word %0d byte %0d got bad frame or timeout, want valid 8N1", k, j);
          return;
        end
        w = {w[WIDTH-9:0], b};
      end
      got_q.push_back(w);
    end
  endtask

  task automatic wait_start(input string name);
    int guard = 0;
    while (tx !== 1'b0 && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: no start bit within 1000 cycles, tx=%b want 0", name, tx);
    end
  endtask

  // Called on the first cycle of a word's start bit; checks tx and busy on every cycle.
  task automatic check_word_frame(input logic [WIDTH-1:0] w, input string name);
    int   errs = 0;
    logic e;
    for (int c = 0; c < WORD_CYCLES; c++) begin
      int bk;
      int pos;
      bk  = c / (10 * CPB);
      pos = (c % (10 * CPB)) / CPB;
      if (pos == 0)      e = 1'b0;
      else if (pos == 9) e = 1'b1;
      else               e = w[5'(WIDTH - 8 - 8 * bk + pos - 1)];
      if (tx !== e || busy !== 1'b1) errs++;
      @(negedge clk);
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s: %0d cycles with wrong tx/busy in frame of %h, want 0", name, errs, w);
    end
  endtask

  task automatic test_reset;
    bit active = 1'b0;
    rst = 1'b1;
    a0  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (fifo_count !== '0)   begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) active = 1'b1;
    end
    n_checks++; if (active) begin n_fail++; $display("FAIL reset_quiet: got activity want idle line for 200 cycles"); end
  endtask

  task automatic test_single_word;
    a0 = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL single_busy_k: got %b want 0", busy); end
    n_checks++; if (fifo_count !== 3'd1)  begin n_fail++; $display("FAIL single_count_k: got %0d want 1", fifo_count); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL single_busy_k1: got %b want 1", busy); end
    n_checks++; if (tx !== 1'b0)          begin n_fail++; $display("FAIL single_tx_k1: got %b want 0", tx); end
    check_word_frame(32'hDEADBEEF, "single_frame");
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_checks++; if (tx !== 1'b1)          begin n_fail++; $display("FAIL single_tx_end: got %b want 1", tx); end
    n_checks++; if (fifo_count !== '0)    begin n_fail++; $display("FAIL single_count_end: got %0d want 0", fifo_count); end
  endtask

  task automatic test_burst;
    int               peak = 0;
    bit               active = 1'b0;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] g;
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    got_q.delete();
    fork
      rx_words(5);
      begin
        for (int v = 1; v <= 6; v++) begin
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
          a0 = WIDTH'(v);
          @(negedge clk);
        end
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        n_checks++; if (overflow !== 1'b1)   begin n_fail++; $display("FAIL burst_overflow: got %b want 1", overflow); end
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL burst_count_full: got %0d want 4", fifo_count); end
      end
    join
    n_checks++; if (peak != 4) begin n_fail++; $display("FAIL burst_peak: got %0d want 4", peak); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL burst_word_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL burst_word: got %h want %h", g, e); end
    end
    repeat (CPB) @(negedge clk);
    repeat (200) begin
      @(negedge clk);
      if (busy !== 1'b0) active = 1'b1;
    end
    n_checks++; if (active) begin n_fail++; $display("FAIL burst_no_sixth: got extra transmission want none"); end
  endtask

  task automatic test_back_to_back;
    a0 = 32'h00000001;
    @(negedge clk);
    a0 = 32'h00000002;
    @(negedge clk);
    wait_start("b2b_start1");
    check_word_frame(32'h00000001, "b2b_frame1");
    n_checks++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got tx=%b busy=%b want tx=1 busy=0", tx, busy); end
    @(negedge clk);
    n_checks++; if (tx !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start2: got tx=%b busy=%b want tx=0 busy=1", tx, busy); end
    check_word_frame(32'h00000002, "b2b_frame2");
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    bit active = 1'b0;
    a0 = 32'h12345678;
    @(negedge clk);
    wait_start("rmf_start");
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1)        begin n_fail++; $display("FAIL rmf_tx: got %b want 1", tx); end
    n_checks++; if (fifo_count !== '0)  begin n_fail++; $display("FAIL rmf_count: got %0d want 0", fifo_count); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rmf_busy: got %b want 0", busy); end
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL rmf_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    wait_start("rmf_restart");
    check_word_frame(32'h12345678, "rmf_frame");
    repeat (200) begin
      @(negedge clk);
      if (busy !== 1'b0) active = 1'b1;
    end
    n_checks++; if (active) begin n_fail++; $display("FAIL rmf_once: got second transmission want one"); end
  endtask

  task automatic test_no_change;
    int   rises = 0;
    logic prev;
    a0   = 32'h00000007;
    prev = busy;
    repeat (500) begin
      @(negedge clk);
      if (busy === 1'b1 && prev === 1'b0) rises++;
      prev = busy;
    end
    n_checks++; if (rises != 1) begin n_fail++; $display("FAIL nochange_words: got %0d want 1", rises); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL nochange_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] g;
    exp_q = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    got_q.delete();
    fork
      rx_words(6);
      begin
        for (int v = 10; v <= 14; v++) begin
          a0 = WIDTH'(v);
          @(negedge clk);
        end
        for (int g2 = 0; g2 < 400 && busy !== 1'b0; g2++) @(negedge clk);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fpp_full: got %0d want 4", fifo_count); end
        a0 = 32'd15;
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fpp_count: got %0d want 4", fifo_count); end
        n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
        n_checks++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL fpp_busy: got %b want 1", busy); end
      end
    join
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL fpp_word_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL fpp_word: got %h want %h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_change();
    test_full_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
